// File: rtl/reg_move_seq_if.sv
// Command/response/box bus for reg_move_seq. The slave modport is the sequencer;
// the master side is the host issuing commands and supplying box read data.
interface reg_move_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       box_save;
  logic       box_load;
  logic [1:0] box_addr;
  logic [7:0] box_in;
  logic [7:0] box_out;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, box_out,
    output cmd_ready, rsp_valid, rsp_data, busy,
           box_save, box_load, box_addr, box_in
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, box_out,
    input  cmd_ready, rsp_valid, rsp_data, busy,
           box_save, box_load, box_addr, box_in
  );
endinterface

// File: rtl/reg_move_seq.sv
// Sequencer for WRITE/READ/COPY/SWAP on an external 4x8 register box.
// Optional macro REG_MOVE_SEQ_SELF_SKIP_EN: COPY/SWAP with a==b completes in IDLE.
module reg_move_seq (
  input  logic           clk,
  input  logic           reset,
  reg_move_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WR, LD_A, LD_B, ST_A, ST_B, RD} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01,
                            OP_COPY  = 2'b10, OP_SWAP = 2'b11} op_t;

  state_t     state;
  op_t        op_q;
  logic [1:0] a_q;
  logic [1:0] b_q;
  logic [7:0] data_q;
  logic [7:0] tmp0;
  logic [7:0] tmp1;
  logic       self_skip;

`ifdef REG_MOVE_SEQ_SELF_SKIP_EN
  assign self_skip = (bus.cmd_a == bus.cmd_b);
`else
  assign self_skip = 1'b0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // Store data is selected from registered operands only, so it is stable
  // for the whole store cycle and zero whenever no store is in progress.
  always_comb begin
    bus.box_in = 8'h00;
    case (state)
      WR:      bus.box_in = data_q;
      ST_A:    bus.box_in = tmp1;
      ST_B:    bus.box_in = tmp0;
      default: bus.box_in = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_WRITE;
      a_q           <= 2'b00;
      b_q           <= 2'b00;
      data_q        <= 8'h00;
      tmp0          <= 8'h00;
      tmp1          <= 8'h00;
      bus.box_save  <= 1'b0;
      bus.box_load  <= 1'b0;
      bus.box_addr  <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'h00;
    end else begin
      // NOTE: non-blocking defaults here make every strobe a one-cycle pulse
      // unless the branch taken below re-asserts it for the next state.
      bus.box_save  <= 1'b0;
      bus.box_load  <= 1'b0;
      bus.box_addr  <= 2'b00;
      bus.rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= op_t'(bus.cmd_op);
            a_q    <= bus.cmd_a;
            b_q    <= bus.cmd_b;
            data_q <= bus.cmd_data;
            case (op_t'(bus.cmd_op))
              OP_WRITE: begin
                state        <= WR;
                bus.box_save <= 1'b1;
                bus.box_addr <= bus.cmd_a;
              end
              OP_READ: begin
                state        <= RD;
                bus.box_load <= 1'b1;
                bus.box_addr <= bus.cmd_a;
              end
              default: begin
                if (!self_skip) begin
                  state        <= LD_A;
                  bus.box_load <= 1'b1;
                  bus.box_addr <= bus.cmd_a;
                end
              end
            endcase
          end
        end

        WR: state <= IDLE;

        RD: begin
          bus.rsp_data  <= bus.box_out;
          bus.rsp_valid <= 1'b1;
          state         <= IDLE;
        end

        LD_A: begin
          tmp0         <= bus.box_out;
          bus.box_addr <= b_q;
          if (op_q == OP_COPY) begin
            state        <= ST_B;
            bus.box_save <= 1'b1;
          end else begin
            state        <= LD_B;
            bus.box_load <= 1'b1;
          end
        end

        LD_B: begin
          tmp1         <= bus.box_out;
          state        <= ST_A;
          bus.box_save <= 1'b1;
          bus.box_addr <= a_q;
        end

        ST_A: begin
          state        <= ST_B;
          bus.box_save <= 1'b1;
          bus.box_addr <= b_q;
        end

        ST_B:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_move_seq.sv
// Self-checking bench for reg_move_seq: behavioural register box, reference
// register model and a response scoreboard.
module tb_reg_move_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_move_seq_if bus ();

  reg_move_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Downstream 4x8 register box
  logic [7:0] box_mem [4];
  assign bus.box_out = bus.box_load ? box_mem[bus.box_addr] : 8'h00;
  always @(posedge clk) if (bus.box_save) box_mem[bus.box_addr] <= bus.box_in;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] ref_regs [4];
  logic [7:0] rsp_q [$];
  logic [9:0] save_log [$];
  int         busy_cycles = 0;
  int         rsp_count = 0;

  // Monitor: scoreboard pops, save log, busy counting, strobe exclusivity
  always @(negedge clk) begin
    logic [7:0] exp_rsp;
    if (bus.box_save) save_log.push_back({bus.box_addr, bus.box_in});
    if (bus.busy) busy_cycles++;
    if (bus.box_save && bus.box_load) begin
      tests_run++; tests_failed++;
      $display("FAIL save_load_overlap got save=1 load=1 required not both");
    end
    if (bus.rsp_valid) begin
      rsp_count++;
      tests_run++;
      if (rsp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rsp_unexpected got data=%02h required no response", bus.rsp_data);
      end else begin
        exp_rsp = rsp_q.pop_front();
        if (bus.rsp_data !== exp_rsp) begin
          tests_failed++;
          $display("FAIL rsp_data got=%02h required=%02h", bus.rsp_data, exp_rsp);
        end
      end
    end
  end

  // Drive one command, hold until accepted; cmd_valid stays high afterwards.
  task automatic send(input logic [1:0] op, input logic [1:0] a,
                      input logic [1:0] b, input logic [7:0] d);
    logic       accepted = 1'b0;
    logic [7:0] t;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_data  = d;
    for (int k = 0; k < 40; k++) begin
      if (bus.cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout got ready=0 required ready=1 op=%0d", op);
    end else begin
      @(posedge clk);
      case (op)
        2'b00: ref_regs[a] = d;
        2'b01: rsp_q.push_back(ref_regs[a]);
        2'b10: ref_regs[b] = ref_regs[a];
        default: begin
          t           = ref_regs[a];
          ref_regs[a] = ref_regs[b];
          ref_regs[b] = t;
        end
      endcase
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy && rsp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL drain_timeout got busy=%0b pending=%0d required idle", bus.busy, rsp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [22:0] got;
    logic [22:0] exp;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_a = 2'b00;
    bus.cmd_b = 2'b00;    bus.cmd_data = 8'h00;
    repeat (2) @(negedge clk);
    got = {bus.cmd_ready, bus.busy, bus.box_save, bus.box_load, bus.box_addr,
           bus.box_in, bus.rsp_valid, bus.rsp_data};
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%06h required=%06h", got, exp);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset got=%0b required=1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_read();
    int rc;
    save_log.delete();
    send(2'b00, 2'd2, 2'd0, 8'hA5);
    drain();
    tests_run++;
    if (save_log.size() !== 1 || save_log[0] !== {2'd2, 8'hA5}) begin
      tests_failed++;
      $display("FAIL write_save got n=%0d first=%03h required n=1 first=%03h",
               save_log.size(), save_log.size() ? save_log[0] : 10'h0, {2'd2, 8'hA5});
    end
    rc = rsp_count;
    send(2'b01, 2'd2, 2'd0, 8'h00);
    drain();
    repeat (3) @(negedge clk);
    tests_run++;
    if (rsp_count - rc !== 1 || bus.rsp_data !== 8'hA5 || bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_pulse got pulses=%0d data=%02h valid=%0b required pulses=1 data=a5 valid=0",
               rsp_count - rc, bus.rsp_data, bus.rsp_valid);
    end
  endtask

  task automatic test_swap();
    send(2'b00, 2'd0, 2'd0, 8'h11);
    send(2'b00, 2'd3, 2'd0, 8'h22);
    drain();
    save_log.delete();
    busy_cycles = 0;
    send(2'b11, 2'd0, 2'd3, 8'h00);
    drain();
    tests_run++;
    if (busy_cycles !== 4) begin
      tests_failed++;
      $display("FAIL swap_busy got=%0d required=4", busy_cycles);
    end
    tests_run++;
    if (save_log.size() !== 2 || save_log[0] !== {2'd0, 8'h22} || save_log[1] !== {2'd3, 8'h11}) begin
      tests_failed++;
      $display("FAIL swap_saves got n=%0d required n=2 (022,311)", save_log.size());
    end
    send(2'b01, 2'd0, 2'd0, 8'h00);
    send(2'b01, 2'd3, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_copy();
    send(2'b00, 2'd1, 2'd0, 8'h5C);
    drain();
    save_log.delete();
    busy_cycles = 0;
    send(2'b10, 2'd1, 2'd2, 8'h00);
    drain();
    tests_run++;
    if (busy_cycles !== 2 || save_log.size() !== 1 || save_log[0] !== {2'd2, 8'h5C}) begin
      tests_failed++;
      $display("FAIL copy_seq got busy=%0d saves=%0d required busy=2 saves=1 (25c)",
               busy_cycles, save_log.size());
    end
    tests_run++;
    if (box_mem[1] !== 8'h5C || box_mem[2] !== 8'h5C) begin
      tests_failed++;
      $display("FAIL copy_box got r1=%02h r2=%02h required r1=5c r2=5c", box_mem[1], box_mem[2]);
    end
    send(2'b01, 2'd1, 2'd0, 8'h00);
    send(2'b01, 2'd2, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_back_to_back();
    int rc;
    save_log.delete();
    rc = rsp_count;
    send(2'b00, 2'd0, 2'd0, 8'h01);
    send(2'b00, 2'd1, 2'd0, 8'h02);
    send(2'b01, 2'd1, 2'd0, 8'h00);
    drain();
    tests_run++;
    if (save_log.size() !== 2 || save_log[0] !== {2'd0, 8'h01} ||
        save_log[1] !== {2'd1, 8'h02} || rsp_count - rc !== 1) begin
      tests_failed++;
      $display("FAIL back_to_back got saves=%0d rsps=%0d required saves=2 rsps=1",
               save_log.size(), rsp_count - rc);
    end
  endtask

  task automatic test_reset_mid_swap();
    logic found = 1'b0;
    send(2'b00, 2'd0, 2'd0, 8'h11);
    send(2'b00, 2'd3, 2'd0, 8'h22);
    drain();
    send(2'b11, 2'd0, 2'd3, 8'h00);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.box_save && bus.box_addr == 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL st_a_timeout got no store to addr 0 required ST_A store");
    end else begin
      reset = 1'b1;
      #1;
      save_log.delete();
      tests_run++;
      if (bus.box_save !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_abort got save=%0b busy=%0b rsp_data=%02h required 0/0/00",
                 bus.box_save, bus.busy, bus.rsp_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (bus.cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL ready_after_abort got=%0b required=1", bus.cmd_ready);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (save_log.size() !== 0 || box_mem[0] !== 8'h11 || box_mem[3] !== 8'h22) begin
        tests_failed++;
        $display("FAIL abort_box got saves=%0d r0=%02h r3=%02h required 0/11/22",
                 save_log.size(), box_mem[0], box_mem[3]);
      end
    end
    // Aborted before any store landed: the box keeps its pre-swap contents.
    ref_regs[0] = 8'h11;
    ref_regs[3] = 8'h22;
    send(2'b01, 2'd0, 2'd0, 8'h00);
    send(2'b01, 2'd3, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_self_swap();
    int exp_busy;
    int exp_saves;
`ifdef REG_MOVE_SEQ_SELF_SKIP_EN
    exp_busy = 0; exp_saves = 0;
`else
    exp_busy = 4; exp_saves = 2;
`endif
    send(2'b00, 2'd1, 2'd0, 8'h77);
    drain();
    save_log.delete();
    busy_cycles = 0;
    send(2'b11, 2'd1, 2'd1, 8'h00);
    drain();
    tests_run++;
    if (busy_cycles !== exp_busy || save_log.size() !== exp_saves) begin
      tests_failed++;
      $display("FAIL self_swap got busy=%0d saves=%0d required busy=%0d saves=%0d",
               busy_cycles, save_log.size(), exp_busy, exp_saves);
    end
    tests_run++;
    if (box_mem[1] !== 8'h77) begin
      tests_failed++;
      $display("FAIL self_swap_box got r1=%02h required=77", box_mem[1]);
    end
    send(2'b01, 2'd1, 2'd0, 8'h00);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      box_mem[i]  = 8'h00;
      ref_regs[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_swap();
    test_copy();
    test_back_to_back();
    test_reset_mid_swap();
    test_self_swap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_move_seq.md
REG_MOVE_SEQ -- requirements
Module: reg_move_seq

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-high; clears all state.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op  input  2  00 WRITE, 01 READ, 10 COPY, 11 SWAP.
REQ-007 cmd_a  input  2  first register index (WRITE/READ target, COPY source, SWAP first).
REQ-008 cmd_b  input  2  second register index (COPY destination, SWAP second).
REQ-009 cmd_data  input  8  WRITE immediate.
REQ-010 rsp_valid  output  1  one-cycle pulse, READ data valid.
REQ-011 rsp_data  output  8  READ result; holds last value.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 box_save, box_load  output  1 each  drive downstream 4x8 register box.
REQ-014 box_addr  output  2; box_in  output  8; box_out  input  8 (combinational read of box at box_addr while box_load=1).

Function
REQ-015 SHALL implement states IDLE, WR, LD_A, LD_B, ST_A, ST_B, RD.
REQ-016 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a clk edge with cmd_valid&&cmd_ready and cmd_op/cmd_a/cmd_b/cmd_data are latched.
REQ-017 Next state after accept: WRITE->WR, READ->RD, COPY->LD_A, SWAP->LD_A.
REQ-018 WR: box_save=1, box_addr=a, box_in=data; -> IDLE.
REQ-019 RD: box_load=1, box_addr=a; edge captures box_out into rsp_data, rsp_valid=1 next cycle only; -> IDLE.
REQ-020 LD_A: box_load=1, box_addr=a; edge captures box_out into tmp0; COPY -> ST_B, SWAP -> LD_B.
REQ-021 LD_B: box_load=1, box_addr=b; captures tmp1; -> ST_A.
REQ-022 ST_A: box_save=1, box_addr=a, box_in=tmp1; -> ST_B.
REQ-023 ST_B: box_save=1, box_addr=b, box_in=(COPY ? tmp0 : tmp0); -> IDLE.
REQ-024 box_save and box_load SHALL never be high in the same cycle; in IDLE box_save=box_load=0, box_addr=0, box_in=0.
REQ-025 Exec cycles after accept: WRITE 1, READ 1, COPY 2, SWAP 4; plus one IDLE cycle before the next accept.
REQ-026 COPY/SWAP with a==b SHALL run the full sequence (contents unchanged) unless REQ-031 applies.
REQ-027 cmd_valid while busy SHALL be ignored (no latch, no side effect).

Reset
REQ-028 On reset assertion, immediately: state=IDLE, box_save=box_load=0, box_addr=0, box_in=0, rsp_valid=0, rsp_data=0, tmp0=tmp1=0, busy=0.
REQ-029 Reset mid-operation SHALL abort the sequence; no further box_save is issued; a SWAP aborted after ST_A leaves the box partially updated (by design).
REQ-030 After reset deasserts, cmd_ready=1 on the first cycle.

Configuration
REQ-031 Macro REG_MOVE_SEQ_SELF_SKIP_EN: when defined, COPY/SWAP with cmd_a==cmd_b accept and remain in IDLE (zero exec cycles, no box_save/box_load); when undefined, REQ-026 holds.

Verification
REQ-032 WRITE a=2 data=0xA5, then READ a=2 -> one box_save at addr 2 with 0xA5; rsp_valid pulses once, rsp_data=0xA5.
REQ-033 Preload r0=0x11, r3=0x22; SWAP a=0 b=3 -> LD_A, LD_B, ST_A(0x22@0), ST_B(0x11@3); READ r0=0x22, r3=0x11; busy high exactly 4 cycles.
REQ-034 Preload r1=0x5C; COPY a=1 b=2 -> ST_B writes 0x5C to addr 2; r1 remains 0x5C.
REQ-035 cmd_valid held high with 3 back-to-back commands -> each accepted only in IDLE; no command lost or duplicated.
REQ-036 Assert reset in ST_A of SWAP r0=0x11/r3=0x22 -> no box_save that cycle onward; r0=0x11, r3=0x22 unchanged; cmd_ready=1 after release.
REQ-037 SWAP a=1 b=1 with and without REG_MOVE_SEQ_SELF_SKIP_EN -> 0 vs 4 busy cycles; r1 unchanged in both.
